// File: rtl/sram_pkg.sv
// Shared constants and types for the dual-port SRAM slice.
package sram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] word_t;
  typedef logic        [DEFAULT_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/sram_port_reg.sv
// Per-port registered read data: clears on reset, returns the port's own
// write data on a write (write-first), otherwise captures the array word
// as it stood before this edge's writes land.
module sram_port_reg #(
  parameter int DATA_WIDTH = sram_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic signed [DATA_WIDTH-1:0] rdata,
  output logic signed [DATA_WIDTH-1:0] q
);

  // Output register: reset clear, then write-first, then old array contents.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes rdata the "old" word here.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= wdata;
    end else begin
      q <= rdata;
    end
  end

endmodule

// File: rtl/dual_port_sram.sv
// True dual-port synchronous RAM: two read/write ports on one clock sharing
// a single array. Port A wins when both ports write the same address.
module dual_port_sram
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_a,
  input  logic signed [DATA_WIDTH-1:0] data_b,
  input  logic        [ADDR_WIDTH-1:0] addr_a,
  input  logic        [ADDR_WIDTH-1:0] addr_b,
  input  logic                         we_a,
  input  logic                         we_b,
  output logic signed [DATA_WIDTH-1:0] q_a,
  output logic signed [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic signed [DATA_WIDTH-1:0] rd_a;
  logic signed [DATA_WIDTH-1:0] rd_b;
  logic                         b_blocked;

  // Array words as they stand before the current edge's writes.
  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

  // Port B loses a same-address write collision to port A.
  assign b_blocked = we_a && (addr_a == addr_b);

  // Array writes; reset only suppresses writes, it never clears contents.
  // NOTE: the storage array deliberately has no reset branch so it maps to
  // RAM macros; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) begin
        mem[addr_a] <= data_a;
      end
      if (we_b && !b_blocked) begin
        mem[addr_b] <= data_b;
      end
    end
  end

  sram_port_reg #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we_a),
    .wdata (data_a),
    .rdata (rd_a),
    .q     (q_a)
  );

  sram_port_reg #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we_b),
    .wdata (data_b),
    .rdata (rd_b),
    .q     (q_b)
  );

endmodule

// File: tb/tb_dual_port_sram.sv
// Self-checking bench for dual_port_sram: random sweeps plus directed corner
// cases, expected values queued per cycle and compared by a monitor.
module tb_dual_port_sram;
  import sram_pkg::*;

  localparam int DEPTH = 2 ** DEFAULT_ADDR_WIDTH;
  localparam longint MIN_NEG = -(64'sd1 <<< 31);

  logic  clk;
  logic  rst;
  word_t data_a, data_b;
  addr_t addr_a, addr_b;
  logic  we_a, we_b;
  word_t q_a, q_b;

  dual_port_sram dut (
    .clk    (clk),
    .rst    (rst),
    .data_a (data_a),
    .data_b (data_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .we_a   (we_a),
    .we_b   (we_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference memory: plain array plus a "has been written" flag per word.
  word_t ref_mem [DEPTH];
  bit    known   [DEPTH];

  // Scoreboard queues, one entry per clock edge.
  word_t exp_a_q [$];
  word_t exp_b_q [$];
  bit    chk_a_q [$];
  bit    chk_b_q [$];
  string name_q  [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: q is sampled on the falling edge, half a cycle after it changes.
  always @(negedge clk) begin
    word_t ea, eb;
    bit    ca, cb;
    string nm;
    if (name_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      ca = chk_a_q.pop_front();
      cb = chk_b_q.pop_front();
      nm = name_q.pop_front();
      if (ca) check({nm, "_qa"}, q_a, ea);
      if (cb) check({nm, "_qb"}, q_b, eb);
    end
  end

  // One clock edge: apply inputs, predict both q values from the port rules,
  // then commit the writes to the reference (A applied last so it wins).
  task automatic step(input bit r,
                      input bit wa, input addr_t aa, input word_t da,
                      input bit wb, input addr_t ab, input word_t db,
                      input string nm);
    word_t ea, eb;
    bit    ca, cb;
    rst = r;
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    if (r)       begin ea = '0; ca = 1'b1; end
    else if (wa) begin ea = da; ca = 1'b1; end
    else         begin ea = ref_mem[int'(aa)]; ca = known[int'(aa)]; end
    if (r)       begin eb = '0; cb = 1'b1; end
    else if (wb) begin eb = db; cb = 1'b1; end
    else         begin eb = ref_mem[int'(ab)]; cb = known[int'(ab)]; end
    @(posedge clk);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    chk_a_q.push_back(ca);
    chk_b_q.push_back(cb);
    name_q.push_back(nm);
    if (!r) begin
      if (wb) begin ref_mem[int'(ab)] = db; known[int'(ab)] = 1'b1; end
      if (wa) begin ref_mem[int'(aa)] = da; known[int'(aa)] = 1'b1; end
    end
    #1;
  endtask

  function automatic addr_t rnd_addr();
    return addr_t'($urandom_range(DEPTH - 1, 0));
  endfunction

  initial begin
    bit drained;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    rst = 1'b1; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

    // Reset state.
    step(1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0, "reset_init");
    step(1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 16'd0, 32'd0, "reset_init");

    // Single-port sweep via port A over the bottom and top 2048 words; port B
    // reads random addresses meanwhile (checked only once written).
    for (int i = 0; i < 4096; i++) begin
      addr_t a = (i < 2048) ? addr_t'(i) : addr_t'(DEPTH - 4096 + i);
      step(1'b0, 1'b1, a, word_t'($urandom), 1'b0, rnd_addr(), 32'd0, "sp_write");
    end
    for (int i = 0; i < 4096; i++) begin
      addr_t a = (i < 2048) ? addr_t'(i) : addr_t'(DEPTH - 4096 + i);
      step(1'b0, 1'b0, a, 32'd0, 1'b0, rnd_addr(), 32'd0, "sp_read");
    end

    // Dual-port sweep: A fills the lower half, B the upper half, then both read.
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b0, 1'b1, addr_t'(i), word_t'($urandom),
           1'b1, addr_t'(i + DEPTH / 2), word_t'($urandom), "dp_write");
    end
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b0, 1'b0, addr_t'(i), 32'd0,
           1'b0, addr_t'(i + DEPTH / 2), 32'd0, "dp_read");
    end

    // Reset suppresses a pending write and clears both outputs.
    step(1'b0, 1'b1, 16'd5, 32'h1234_5678, 1'b0, 16'd5, 32'd0, "rst_setup");
    step(1'b0, 1'b0, 16'd5, 32'd0, 1'b0, 16'd5, 32'd0, "rst_preread");
    step(1'b1, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0, 16'd5, 32'd0, "rst_clear");
    step(1'b0, 1'b0, 16'd5, 32'd0, 1'b0, 16'd5, 32'd0, "rst_suppress");
    check("rst_suppress_direct", q_a, 32'h1234_5678);

    // Same-port write-first.
    step(1'b0, 1'b1, 16'd7, 32'hCAFE_F00D, 1'b0, 16'd5, 32'd0, "write_first");
    check("write_first_direct", q_a, 32'hCAFE_F00D);

    // Cross-port read-during-write returns old data, new data next cycle.
    step(1'b0, 1'b1, 16'd9, 32'h1111_1111, 1'b0, 16'd7, 32'd0, "xport_setup");
    step(1'b0, 1'b1, 16'd9, 32'h2222_2222, 1'b0, 16'd9, 32'd0, "xport_old");
    check("xport_old_direct", q_b, 32'h1111_1111);
    step(1'b0, 1'b0, 16'd7, 32'd0, 1'b0, 16'd9, 32'd0, "xport_new");
    check("xport_new_direct", q_b, 32'h2222_2222);
    // Mirror case: B writes while A reads.
    step(1'b0, 1'b0, 16'd9, 32'd0, 1'b1, 16'd9, 32'h3333_3333, "xport_ba_old");
    step(1'b0, 1'b0, 16'd9, 32'd0, 1'b0, 16'd7, 32'd0, "xport_ba_new");

    // Write collision: A stored, each port echoes its own data.
    step(1'b0, 1'b1, 16'h00FF, 32'hAAAA_AAAA, 1'b1, 16'h00FF, 32'hBBBB_BBBB, "collide");
    check("collide_qb_direct", q_b, 32'hBBBB_BBBB);
    step(1'b0, 1'b0, 16'h00FF, 32'd0, 1'b0, 16'h00FF, 32'd0, "collide_read");
    check("collide_read_direct", q_b, 32'hAAAA_AAAA);

    // Signed storage of the most negative word.
    step(1'b0, 1'b1, 16'h0100, 32'h8000_0000, 1'b0, 16'd0, 32'd0, "sign_write");
    step(1'b0, 1'b0, 16'h0100, 32'd0, 1'b0, 16'h0100, 32'd0, "sign_read");
    check("sign_value", q_a, word_t'(MIN_NEG));
    check("sign_negative", word_t'($signed(q_a) < 0), 32'd1);

    // Random mixed traffic, including collisions within a small address pool.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(49, 0) == 0),
           1'($urandom), addr_t'($urandom_range(15, 0)), word_t'($urandom),
           1'($urandom), addr_t'($urandom_range(15, 0)), word_t'($urandom),
           "random_mix");
    end

    // Drain the scoreboard with a bounded wait.
    drained = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (name_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", name_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_sram.md
Name: dual_port_sram

Overview:
- True dual-port synchronous RAM: two independent read/write ports (A, B) share one storage array of 2**ADDR_WIDTH words.
- Both ports are clocked by a single clock.
- Memory-controller building block; each port writes or reads one word per cycle with registered read data.

Parameters:
- DATA_WIDTH, 32, word width in bits; data is treated as signed.
- ADDR_WIDTH, 16, address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- data_a  input  DATA_WIDTH (signed)  port A write data.
- data_b  input  DATA_WIDTH (signed)  port B write data.
- addr_a  input  ADDR_WIDTH  port A address.
- addr_b  input  ADDR_WIDTH  port B address.
- we_a  input  1  port A write enable; 1 = write, 0 = read.
- we_b  input  1  port B write enable; 1 = write, 0 = read.
- q_a  output  DATA_WIDTH (signed)  port A registered read data.
- q_b  output  DATA_WIDTH (signed)  port B registered read data.

Interface note: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Storage: array mem[0 .. 2**ADDR_WIDTH-1] of DATA_WIDTH bits.
  - Not cleared by reset; contents are undefined until written.
  - Every address is reachable; no wrap or aliasing inside the range.
- Reset: with rst=1 at a rising edge, q_a and q_b become 0 and writes are suppressed that cycle. rst has priority over we_a and we_b.
- Read, we_x=0: at rising edge k, q_x <= mem[addr_x]. q_x is valid after edge k and holds until the next edge. Latency is 1 cycle.
- Write, we_x=1: at rising edge k, mem[addr_x] <= data_x.
  - Same-port read-during-write is write-first: q_x <= data_x at the same edge.
- Pipelined reads: the address may change every cycle. q_x always reflects the address sampled at the previous edge, giving one new word per cycle.
- Cross-port read-during-write (A writes address N, B reads N at the same edge): the reading port returns the old contents of N. The new value is visible from the next read onward. The rule is symmetric for B writing and A reading.
- Write collision (both we=1, same address): port A's data is stored; port B's write is dropped. Each port's q still returns its own data_x (write-first).
- Both ports reading the same address: both return the identical stored value.
- Outputs are purely registered; there is no combinational path from inputs to q_a or q_b.
- No handshake; the RAM accepts a request every cycle on each port.

Decomposition:
- Package sram_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - typedefs word_t (logic signed [DATA_WIDTH-1:0]) and addr_t (logic [ADDR_WIDTH-1:0]).
- Natural sub-module sram_port_reg: per-port output register implementing reset clear, write-first select and old-data capture. It is instantiated twice.
- Storage array and collision priority live in the top module.

Test Plan:
- Single-port sweep:
  - Write random values to all 65536 addresses via port A, one per cycle.
  - Then read addresses 0..65535 with the address advanced each cycle.
  - Required: q_a equals the value written at the address presented one cycle earlier, 0 mismatches.
- Dual-port sweep:
  - In 32768 cycles, port A writes addresses 0..32767 and port B writes addresses 32768..65535 simultaneously, random data.
  - Then both ports read their halves in parallel.
  - Required: q_a and q_b match their respective writes with 1-cycle latency, 0 mismatches.
- Reset:
  - Read address 5 holding 0x1234_5678; next cycle assert rst with we_a=1, addr_a=5, data_a=0xDEAD_BEEF.
  - Required: q_a=0 and q_b=0 after the reset edge.
  - Required: a subsequent read of address 5 returns 0x1234_5678 (write suppressed).
- Write-first, same port:
  - Write port A at address 7 with data 0xCAFE_F00D.
  - Required: q_a=0xCAFE_F00D after the same edge.
- Cross-port read-during-write:
  - Address 9 holds 0x1111_1111; at one edge, A writes 0x2222_2222 to address 9 while B reads address 9.
  - Required: q_b=0x1111_1111; B reading address 9 on the next cycle returns 0x2222_2222.
- Write collision:
  - A writes 0xAAAA_AAAA and B writes 0xBBBB_BBBB to address 0x00FF at the same edge.
  - Required: q_a=0xAAAA_AAAA and q_b=0xBBBB_BBBB that cycle; a later read of 0x00FF on either port returns 0xAAAA_AAAA.
  - Also check sign: storing 0x8000_0000 reads back as -2147483648.
